// File: rtl/zaq_irq_pkg.sv
// Shared constants for the zaq interrupt bank: register map, ID word, reset limit.
package zaq_irq_pkg;

    localparam logic [2:0] ADDR_INV       = 3'd0;
    localparam logic [2:0] ADDR_RISE_EN   = 3'd1;
    localparam logic [2:0] ADDR_FALL_EN   = 3'd2;
    localparam logic [2:0] ADDR_MASK      = 3'd3;
    localparam logic [2:0] ADDR_STATUS    = 3'd4;
    localparam logic [2:0] ADDR_DEB_LIMIT = 3'd5;
    localparam logic [2:0] ADDR_STABLE    = 3'd6;
    localparam logic [2:0] ADDR_ID        = 3'd7;

    // ID register reports the channel count.
    function automatic logic [31:0] id_word(input int n_ch);
        return 32'(n_ch);
    endfunction

    // Debounce limit comes out of reset at its maximum (all ones).
    function automatic logic [15:0] deb_limit_default(input int deb_w);
        return 16'((32'd1 << deb_w) - 32'd1);
    endfunction

endpackage

// File: rtl/zaq_deb_ch.sv
// One input channel: 2-flop synchroniser, polarity XOR, debounce counter,
// stable level and one-cycle edge pulses aligned with the stable update.
module zaq_deb_ch #(
    parameter int DEB_W = 8
) (
    input  logic             sysclk,
    input  logic             reset_n,
    input  logic             i_raw,
    input  logic             i_inv,
    input  logic [DEB_W-1:0] i_limit,
    output logic             o_stable,
    output logic             o_rise,
    output logic             o_fall
);

    logic             r_s1, r_s2;
    logic             r_stable, r_rise, r_fall;
    logic [DEB_W-1:0] r_cnt;
    logic             w_sync, w_flip;

    assign w_sync = r_s2 ^ i_inv;
    // >= rather than == so a limit lowered under a running count still flips.
    assign w_flip = (w_sync != r_stable) && (r_cnt >= i_limit);

    // Two-stage synchroniser for the asynchronous raw input.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_raw;
            r_s2 <= r_s1;
        end
    end

    // Count consecutive mismatch cycles; adopt the new level once the limit is reached.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt    <= '0;
            r_stable <= 1'b0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
        end else begin
            r_rise <= w_flip & w_sync;
            r_fall <= w_flip & ~w_sync;
            if (w_sync == r_stable) begin
                r_cnt <= '0;
            end else if (w_flip) begin
                r_stable <= w_sync;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_stable = r_stable;
    assign o_rise   = r_rise;
    assign o_fall   = r_fall;

endmodule

// File: rtl/zaq_irq_bank.sv
// Debounced interrupt bank: per-channel debouncers, register file,
// sticky W1C status and a registered masked interrupt.
module zaq_irq_bank
    import zaq_irq_pkg::*;
#(
    parameter int N_CH  = 16,
    parameter int DEB_W = 8
) (
    input  logic            sysclk,
    input  logic            reset_n,
    input  logic [N_CH-1:0] g_zaq_in,
    input  logic            g_wrb,
    input  logic            g_rdb,
    input  logic [2:0]      g_addr,
    input  logic [31:0]     din,
    output logic [31:0]     g_dout,
    output logic            g_irq,
    output logic [N_CH-1:0] g_stable
);

    localparam logic [DEB_W-1:0] DEB_RST = DEB_W'(deb_limit_default(DEB_W));

    logic [N_CH-1:0]  r_inv, r_rise_en, r_fall_en, r_mask, r_status;
    logic [DEB_W-1:0] r_deb_limit;
    logic             r_irq;

    logic [N_CH-1:0]  w_stable, w_rise, w_fall, w_set, w_clr, w_din_ch;
    logic             w_wr;
    logic [31:0]      w_dout;

    assign w_wr     = ~g_wrb;
    assign w_din_ch = din[N_CH-1:0];

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            zaq_deb_ch #(.DEB_W(DEB_W)) u_ch (
                .sysclk   (sysclk),
                .reset_n  (reset_n),
                .i_raw    (g_zaq_in[gi]),
                .i_inv    (r_inv[gi]),
                .i_limit  (r_deb_limit),
                .o_stable (w_stable[gi]),
                .o_rise   (w_rise[gi]),
                .o_fall   (w_fall[gi])
            );
        end
    endgenerate

    // Writable control registers; RO addresses fall through untouched.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            r_inv       <= '0;
            r_rise_en   <= '0;
            r_fall_en   <= '0;
            r_mask      <= '0;
            r_deb_limit <= DEB_RST;
        end else if (w_wr) begin
            case (g_addr)
                ADDR_INV:       r_inv       <= w_din_ch;
                ADDR_RISE_EN:   r_rise_en   <= w_din_ch;
                ADDR_FALL_EN:   r_fall_en   <= w_din_ch;
                ADDR_MASK:      r_mask      <= w_din_ch;
                ADDR_DEB_LIMIT: r_deb_limit <= din[DEB_W-1:0];
                default: ;
            endcase
        end
    end

    assign w_set = (w_rise & r_rise_en) | (w_fall & r_fall_en);
    assign w_clr = (w_wr && g_addr == ADDR_STATUS) ? w_din_ch : '0;

    // Sticky status: a set event in the same cycle as its W1C keeps the bit.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) r_status <= '0;
        else          r_status <= (r_status & ~w_clr) | w_set;
    end

    // Interrupt follows status and mask with one register of delay.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) r_irq <= 1'b0;
        else          r_irq <= |(r_status & r_mask);
    end

    // Read mux: all-ones while idle, unused upper bits read as zero.
    always_comb begin
        w_dout = '1;
        if (!g_rdb) begin
            case (g_addr)
                ADDR_INV:       w_dout = 32'(r_inv);
                ADDR_RISE_EN:   w_dout = 32'(r_rise_en);
                ADDR_FALL_EN:   w_dout = 32'(r_fall_en);
                ADDR_MASK:      w_dout = 32'(r_mask);
                ADDR_STATUS:    w_dout = 32'(r_status);
                ADDR_DEB_LIMIT: w_dout = 32'(r_deb_limit);
                ADDR_STABLE:    w_dout = 32'(w_stable);
                default:        w_dout = id_word(N_CH);
            endcase
        end
    end

    assign g_dout   = w_dout;
    assign g_irq    = r_irq;
    assign g_stable = w_stable;

endmodule

// File: tb/tb_zaq_irq_bank.sv
// Bench for zaq_irq_bank: cycle model of the channel/register behaviour,
// read expectations queued at issue time and popped by a negedge monitor.
module tb_zaq_irq_bank;

    localparam int NC = 16;

    logic          sysclk;
    logic          reset_n;
    logic [NC-1:0] g_zaq_in;
    logic          g_wrb, g_rdb;
    logic [2:0]    g_addr;
    logic [31:0]   din;
    logic [31:0]   g_dout;
    logic          g_irq;
    logic [NC-1:0] g_stable;

    zaq_irq_bank #(.N_CH(NC), .DEB_W(8)) dut (
        .sysclk   (sysclk),
        .reset_n  (reset_n),
        .g_zaq_in (g_zaq_in),
        .g_wrb    (g_wrb),
        .g_rdb    (g_rdb),
        .g_addr   (g_addr),
        .din      (din),
        .g_dout   (g_dout),
        .g_irq    (g_irq),
        .g_stable (g_stable)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] rdq[$];

    // Reference state
    logic [NC-1:0] m_d1, m_d2, m_stable, m_inv, m_ren, m_fen, m_mask, m_status;
    logic [NC-1:0] m_rose, m_fell;
    logic [7:0]    m_lim;
    logic          m_irq;
    int            m_age[NC];   // consecutive cycles the synced level has disagreed

    always @(posedge sysclk or negedge reset_n) begin : model
        logic [NC-1:0] sy, nst, clr;
        if (!reset_n) begin
            m_d1 <= '0; m_d2 <= '0; m_stable <= '0; m_inv <= '0; m_ren <= '0;
            m_fen <= '0; m_mask <= '0; m_status <= '0; m_rose <= '0; m_fell <= '0;
            m_lim <= 8'hFF; m_irq <= 1'b0;
            for (int i = 0; i < NC; i++) m_age[i] <= 0;
        end else begin
            sy  = m_d2 ^ m_inv;
            nst = m_stable;
            for (int i = 0; i < NC; i++) begin
                if (sy[i] == m_stable[i]) m_age[i] <= 0;
                else if (m_age[i] + 1 > int'(m_lim)) begin
                    nst[i] = sy[i];
                    m_age[i] <= 0;
                end else m_age[i] <= m_age[i] + 1;
            end
            m_rose   <= nst & ~m_stable;
            m_fell   <= ~nst & m_stable;
            m_stable <= nst;
            m_d1     <= g_zaq_in;
            m_d2     <= m_d1;
            clr = (!g_wrb && g_addr == 3'd4) ? din[NC-1:0] : '0;
            m_status <= (m_status & ~clr) | (m_rose & m_ren) | (m_fell & m_fen);
            m_irq    <= |(m_status & m_mask);
            if (!g_wrb) begin
                case (g_addr)
                    3'd0: m_inv  <= din[NC-1:0];
                    3'd1: m_ren  <= din[NC-1:0];
                    3'd2: m_fen  <= din[NC-1:0];
                    3'd3: m_mask <= din[NC-1:0];
                    3'd5: m_lim  <= din[7:0];
                    default: ;
                endcase
            end
        end
    end

    function automatic logic [31:0] exp_rd(input logic [2:0] a);
        case (a)
            3'd0: return {16'h0, m_inv};
            3'd1: return {16'h0, m_ren};
            3'd2: return {16'h0, m_fen};
            3'd3: return {16'h0, m_mask};
            3'd4: return {16'h0, m_status};
            3'd5: return {24'h0, m_lim};
            3'd6: return {16'h0, m_stable};
            default: return 32'd16;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", nm, got, want, $time);
        end
    endtask

    // Monitor: every cycle compare levels/irq, and consume read expectations.
    always @(negedge sysclk) begin
        chk("stable", {16'h0, g_stable}, {16'h0, m_stable});
        chk("irq", {31'h0, g_irq}, {31'h0, m_irq});
        if (!g_rdb) begin
            if (rdq.size() == 0) chk("read_unexpected", g_dout, 32'hDEAD_BEEF);
            else chk("read", g_dout, rdq.pop_front());
        end else begin
            chk("idle_dout", g_dout, 32'hFFFF_FFFF);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge sysclk);
            #1;
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        g_wrb = 1'b0; g_addr = a; din = d;
        tick();
        g_wrb = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a);
        g_rdb = 1'b0; g_addr = a;
        rdq.push_back(exp_rd(a));
        tick();
        g_rdb = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0; g_zaq_in = '0; g_wrb = 1'b1; g_rdb = 1'b1; g_addr = '0; din = '0;
        tick(3);
        for (int a = 0; a < 8; a++) rd(3'(a));   // reset values incl. limit 0xFF, ID 16
        reset_n = 1'b1;
        tick();

        // Rise on ch0 with limit 3: stable, then status, then irq.
        wr(3'd5, 32'd3); wr(3'd1, 32'h1); wr(3'd3, 32'h1);
        g_zaq_in[0] = 1'b1;
        tick(9);
        rd(3'd4);
        // Short pulse on ch1 must be filtered.
        g_zaq_in[1] = 1'b1; tick(3); g_zaq_in[1] = 1'b0;
        tick(8);
        rd(3'd4); rd(3'd6);

        // W1C colliding with a fresh rise event on ch0.
        g_zaq_in[0] = 1'b0; tick(10);
        g_zaq_in[0] = 1'b1; tick(6);
        wr(3'd4, 32'h1);
        rd(3'd4);
        tick(4);
        wr(3'd4, 32'h1);
        tick(2); rd(3'd4);

        // Fall on ch2 with mask off, then enable mask.
        wr(3'd2, 32'h4); wr(3'd3, 32'h0);
        g_zaq_in[2] = 1'b1; tick(10);
        g_zaq_in[2] = 1'b0; tick(10);
        rd(3'd4);
        wr(3'd3, 32'h4);
        tick(2);

        // Writes to RO addresses and out-of-range bits.
        wr(3'd6, 32'hFFFF_FFFF); wr(3'd7, 32'h0); wr(3'd0, 32'hFFFF_0000);
        rd(3'd6); rd(3'd7); rd(3'd0);
        wr(3'd0, 32'h0); tick(10);

        // Randomized traffic.
        for (int k = 0; k < 2000; k++) begin
            int r;
            if ($urandom_range(0, 5) == 0) g_zaq_in = g_zaq_in ^ 16'(32'd1 << $urandom_range(0, 15));
            r = $urandom_range(0, 11);
            if (r == 0) begin
                g_wrb = 1'b0; g_addr = 3'($urandom_range(0, 7)); din = $urandom;
                if (g_addr == 3'd5) din = $urandom_range(0, 6);
                if (g_addr == 3'd0 && $urandom_range(0, 3) != 0) din = 32'h0;
            end else if (r < 4) begin
                g_rdb = 1'b0; g_addr = 3'($urandom_range(0, 7));
                rdq.push_back(exp_rd(g_addr));
            end
            tick();
            g_wrb = 1'b1; g_rdb = 1'b1;
        end

        // Reset in the middle of a debounce.
        wr(3'd5, 32'd3); wr(3'd0, 32'h0);
        g_zaq_in = '0; tick(12);
        g_zaq_in[3] = 1'b1; tick(4);
        reset_n = 1'b0; tick(2);
        rd(3'd5); rd(3'd7); rd(3'd4);
        tick(2);
        reset_n = 1'b1; tick(12);
        rd(3'd6); rd(3'd4);

        tick(2);
        chk("queue_drained", 32'(rdq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/zaq_irq_bank.md
ZAQ_IRQ_BANK -- requirements
Module: zaq_irq_bank

Interface
REQ-001 Parameter N_CH, default 16: channel count, legal range 1..32.
REQ-002 Parameter DEB_W, default 8: debounce counter width, legal range 1..16.
REQ-003 sysclk  in  1  sole clock; all state updates on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 g_zaq_in  in  N_CH  raw asynchronous channel inputs.
REQ-006 g_wrb  in  1  active-low write strobe; one register write per sysclk cycle while low.
REQ-007 g_rdb  in  1  active-low read strobe.
REQ-008 g_addr  in  3  register select.
REQ-009 din  in  32  write data.
REQ-010 g_dout  out  32  read data.
REQ-011 g_irq  out  1  registered interrupt request.
REQ-012 g_stable  out  N_CH  debounced, polarity-corrected channel levels.

Function
REQ-013 Register map: 0 INV (RW), 1 RISE_EN (RW), 2 FALL_EN (RW), 3 MASK (RW), 4 STATUS (RO, write-1-to-clear), 5 DEB_LIMIT (RW, DEB_W bits), 6 STABLE (RO), 7 ID (RO, reads N_CH).
REQ-014 Register field bits at N_CH and above (DEB_W and above for DEB_LIMIT) shall read 0; writes to them, and to RO addresses 6 and 7, shall be ignored.
REQ-015 g_dout shall be combinational: selected register while g_rdb=0, all-ones while g_rdb=1.
REQ-016 Each channel shall pass through a 2-flop synchroniser, then be XORed with INV[i] to form sync[i].
REQ-017 Per-channel counter cnt[i], DEB_W bits:
- when sync[i]==stable[i], cnt[i] <= 0;
- otherwise, if cnt[i]==DEB_LIMIT, stable[i] <= sync[i] and cnt[i] <= 0;
- otherwise cnt[i] <= cnt[i]+1.
REQ-018 Debounce latency shall follow from REQ-017: stable[i] updates DEB_LIMIT+1 cycles after sync[i] first differs, provided sync[i] holds the new level throughout. DEB_LIMIT=0 gives a 1-cycle update. A glitch shorter than DEB_LIMIT+1 cycles shall not change stable[i].
REQ-019 cnt[i] shall never wrap; DEB_LIMIT = 2^DEB_W-1 is legal.
REQ-020 A write to DEB_LIMIT shall take effect the next cycle. A counter already at or above the new limit shall update stable[i] on its next mismatching cycle.
REQ-021 A write to INV shall not itself set STATUS on the write cycle. The resulting level change is debounced normally and sets STATUS when stable[i] changes.
REQ-022 STATUS[i] <= 1 in the cycle after stable[i] rises with RISE_EN[i]=1, or falls with FALL_EN[i]=1.
REQ-023 STATUS set shall be independent of MASK.
REQ-024 A W1C write to STATUS in the same cycle as a set event on the same bit shall leave the bit 1 (set wins).
REQ-025 g_irq <= |(STATUS & MASK) each cycle: one cycle after STATUS or MASK changes.
REQ-026 g_stable shall equal stable directly, with no extra register.

Reset
REQ-027 While reset_n=0:
- synchronisers, cnt, stable, STATUS, INV, RISE_EN, FALL_EN and MASK shall be 0;
- DEB_LIMIT shall be all-ones;
- g_irq shall be 0 and g_stable shall be 0.
REQ-028 Reset mid-debounce shall discard the count.
REQ-029 After reset_n deasserts, an input held high shall set STATUS only if RISE_EN is programmed before stable rises.

Structure
REQ-030 Shared package zaq_irq_pkg shall hold the register address constants, the ID encoding and the default DEB_LIMIT rule.
REQ-031 One sub-module, zaq_deb_ch, shall hold one channel (synchroniser, INV XOR, counter, stable flop, edge outputs). It shall be instantiated N_CH times by a generate loop.
REQ-032 Register file, STATUS logic and irq logic shall stay in the top level.

Verification
REQ-033 N_CH=16, DEB_LIMIT=3, RISE_EN=0x1, MASK=0x1; g_zaq_in[0] 0->1 held -> stable[0] rises 6 cycles after the input edge (2 sync + 4), STATUS=0x0001 next cycle, g_irq=1 one cycle later.
REQ-034 DEB_LIMIT=3; 3-cycle pulse on g_zaq_in[1] -> stable[1], STATUS and g_irq remain 0.
REQ-035 Set STATUS[0]; write STATUS=0x1 in the same cycle as a new rise event on channel 0 -> STATUS[0] remains 1. A later W1C with no event -> STATUS[0]=0, g_irq=0 one cycle later.
REQ-036 FALL_EN=0x4, MASK=0; channel 2 falls -> STATUS=0x0004 with g_irq=0. Then write MASK=0x4 -> g_irq=1 the next cycle.
REQ-037 reset_n pulsed low mid-debounce (cnt=2) -> all outputs 0 and DEB_LIMIT reads 0xFF. g_rdb=1 -> g_dout=0xFFFFFFFF; read ID -> 16.
